a1csah_pipe: RTL and testbench

A1CSAH_PIPE -- requirements
Module: a1csah_pipe

---
 rtl/a1csah_pipe.sv | 171 +++++++++++++++++
 tb/tb_a1csah_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/a1csah_pipe.sv
// Pipelined add-one carry-select adder/subtractor. Each stage resolves one N/S-bit slice.
// Latency S cycles; one result per cycle when the consumer keeps out_ready high.
// Backpressure: global stall, in_ready = !out_valid | out_ready, and every stage holds when stalled.
module a1csah_pipe #(
    parameter int N = 32,
    parameter int M = 4,
    parameter int S = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         gen,
    output logic         prop,
    output logic         ovf
);

    localparam int W  = N / S;   // bits per stage slice
    localparam int NB = W / M;   // carry-select blocks per slice

    logic         adv;
    logic [N-1:0] bx;
    logic         c0;

    // Subtraction is a + ~b + 1; the effective operand travels down the pipe.
    always_comb begin
        bx = sub ? ~b : b;
        c0 = sub ? 1'b1 : cin;
    end

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < S; k++) begin : g_stg
        localparam int LO = k * W;   // lowest global bit of this slice
        localparam int BW = N - LO;  // effective-B bits still undelivered at entry

        logic          v_in;
        logic          c_in;
        logic          g_in;
        logic          p_in;
        logic [N-1:0]  w_in;   // low bits: finished sums, upper bits: operand A
        logic [BW-1:0] b_in;   // bit 0 is global bit LO

        if (k == 0) begin : g_src
            // Neutral group seed: gen=0, prop=1 leaves the first slice's terms unchanged.
            assign v_in = in_valid;
            assign c_in = c0;
            assign g_in = 1'b0;
            assign p_in = 1'b1;
            assign w_in = a;
            assign b_in = bx;
        end else begin : g_src
            assign v_in = g_stg[k-1].v_q;
            assign c_in = g_stg[k-1].c_q;
            assign g_in = g_stg[k-1].g_q;
            assign p_in = g_stg[k-1].p_q;
            assign w_in = g_stg[k-1].w_q;
            assign b_in = g_stg[k-1].g_bx.bx_q;
        end

        logic [W-1:0] sl_sum;
        logic         sl_c;
        logic         sl_g;
        logic         sl_p;
        logic [M:0]   blk_sum0;
        logic [M-1:0] blk_sum1;
        logic [M-1:0] blk_a;
        logic [M-1:0] blk_b;
        logic         blk_g;
        logic         blk_p;
        logic [N-1:0] w_d;

        // Slice adder: each block precomputes a+b and a+b+1, the rippling block carry picks one.
        always_comb begin
            sl_sum   = '0;
            sl_c     = c_in;
            sl_g     = 1'b0;
            sl_p     = 1'b1;
            blk_sum0 = '0;
            blk_sum1 = '0;
            blk_a    = '0;
            blk_b    = '0;
            blk_g    = 1'b0;
            blk_p    = 1'b0;
            for (int j = 0; j < NB; j++) begin
                blk_a    = w_in[LO + j*M +: M];
                blk_b    = b_in[j*M +: M];
                blk_sum0 = {1'b0, blk_a} + {1'b0, blk_b};
                blk_g    = blk_sum0[M];
                blk_p    = &(blk_a ^ blk_b);
                blk_sum1 = blk_sum0[M-1:0] + M'(1);
                sl_sum[j*M +: M] = sl_c ? blk_sum1 : blk_sum0[M-1:0];
                sl_c     = blk_g | (blk_p & sl_c);
                sl_g     = blk_g | (blk_p & sl_g);
                sl_p     = blk_p & sl_p;
            end
        end

        // Splice the new slice into the word; lower slices ride along as the skew delay.
        always_comb begin
            w_d           = w_in;
            w_d[LO +: W]  = sl_sum;
        end

        logic         v_q;
        logic         c_q;
        logic         g_q;
        logic         p_q;
        logic [N-1:0] w_q;

        // Stage register: valid moves on every advance, data only when a real operand arrives.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                g_q <= 1'b0;
                p_q <= 1'b0;
                w_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q <= sl_c;
                    g_q <= sl_g | (sl_p & g_in);
                    p_q <= sl_p & p_in;
                    w_q <= w_d;
                end
            end
        end

        if (k < S - 1) begin : g_bx
            logic [BW-W-1:0] bx_q;

            // Effective B for the slices not yet summed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bx_q <= '0;
                end else if (adv && v_in) begin
                    bx_q <= b_in[BW-1:W];
                end
            end
        end else begin : g_ovf
            logic ovf_q;

            // Carry into the MSB is a^b^sum there; overflow is that carry against carry out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_q <= w_in[N-1] ^ b_in[BW-1] ^ sl_sum[W-1] ^ sl_c;
                end
            end
        end
    end

    assign out_valid = g_stg[S-1].v_q;
    assign s         = g_stg[S-1].w_q;
    assign cout      = g_stg[S-1].c_q;
    assign gen       = g_stg[S-1].g_q;
    assign prop      = g_stg[S-1].p_q;
    assign ovf       = g_stg[S-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_a1csah_pipe.sv
// Scoreboard bench for a1csah_pipe at N=32, M=4, S=2.
// Expected results are queued at each accept and compared whenever a result is presented.
// Random in_valid/out_ready exercises stall and bubble handling.
module tb_a1csah_pipe;

    localparam int N = 32;
    localparam int M = 4;
    localparam int S = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
    logic         gen;
    logic         prop;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;

    logic [N+3:0] exp_q [$];

    a1csah_pipe #(.N(N), .M(M), .S(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .gen       (gen),
        .prop      (prop),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, prop, gen, cout, s}
    function automatic logic [N+3:0] ref_res(input logic [N-1:0] av, input logic [N-1:0] bv,
                                             input logic ci, input logic sb);
        logic [N-1:0] bxv;
        logic         c0v;
        logic [N:0]   full;
        logic [N:0]   nocin;
        logic [N-1:0] low;
        bxv   = sb ? ~bv : bv;
        c0v   = sb ? 1'b1 : ci;
        full  = {1'b0, av} + {1'b0, bxv} + (N+1)'(c0v);
        nocin = {1'b0, av} + {1'b0, bxv};
        low   = {1'b0, av[N-2:0]} + {1'b0, bxv[N-2:0]} + N'(c0v);
        return {low[N-1] ^ full[N], &(av ^ bxv), nocin[N], full[N], full[N-1:0]};
    endfunction

    // One clock: drive after the falling edge, sample before the rising edge.
    task automatic step(input logic v, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic ci, input logic sb, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        a         = v ? av : N'($urandom);
        b         = v ? bv : N'($urandom);
        cin       = v ? ci : 1'($urandom);
        sub       = v ? sb : 1'($urandom);
        out_ready = ordy;
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                chk("result", 64'({ovf, prop, gen, cout, s}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_res(a, b, cin, sub));
            n_acc++;
        end
    endtask

    task automatic op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ci, input logic sb);
        step(1'b1, av, bv, ci, sb, 1'b1);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_data", 64'({ovf, prop, gen, cout, s}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-ones plus carry-in: wraps to zero; also checks two-cycle latency.
        op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        idle(1, 1'b1);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("wrap_s", 64'(s), 64'h0);
        chk("wrap_flags", 64'({cout, prop, gen, ovf}), 64'b1100);

        // Positive overflow; carry crosses the slice boundary at bit 16.
        op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        idle(2, 1'b1);
        chk("ovf_s", 64'(s), 64'h8000_0000);
        chk("ovf_flag", 64'({cout, ovf}), 64'b01);

        // Subtraction in both orders.
        op(32'd5, 32'd7, 1'b0, 1'b1);
        op(32'd7, 32'd5, 1'b0, 1'b1);
        idle(1, 1'b1);
        chk("sub_neg_s", 64'({cout, ovf, s}), {30'd0, 2'b00, 32'hFFFF_FFFE});
        idle(1, 1'b1);
        chk("sub_pos_s", 64'({cout, s}), {31'd0, 1'b1, 32'h2});

        // Four back-to-back, then a three-cycle stall.
        for (int i = 0; i < 4; i++) op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 3; i++) begin
            idle(1, 1'b0);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        idle(4, 1'b1);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two results in flight.
        op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        op(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(6, 1'b1);

        // Random traffic with random bubbles and backpressure.
        n_acc = 0;
        for (int i = 0; i < 40000 && n_acc < 10000; i++) begin
            step(($urandom_range(0, 9) < 7), N'($urandom), N'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 9) < 7));
        end
        chk("rand_accepted", 64'(n_acc), 64'd10000);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1, 1'b1);
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
